// File: rtl/next_pc_unit.sv
`default_nettype none
// ============================================================================
// Module   : next_pc_unit
// Brief    : Next-PC selection with trap/branch/return priority, alignment
//            checking and a circular return-address stack.
// Revision : 1.0 - initial release
// ============================================================================
module next_pc_unit #(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0,
    parameter int              RAS_DEPTH    = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            en,
    input  logic            br_taken,
    input  logic [XLEN-1:0] br_target,
    input  logic            trap,
    input  logic [XLEN-1:0] trap_vector,
    input  logic            ras_push,
    input  logic            ras_pop,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] pc_plus4,
    output logic            misalign,
    output logic [XLEN-1:0] bad_addr,
    output logic            ras_empty,
    output logic            ras_full
);

    localparam int PW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
    localparam int CW = $clog2(RAS_DEPTH + 1);

    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] bad_q, bad_d;
    logic            mis_q, mis_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [PW-1:0]   ptr_q, ptr_d;
    logic [XLEN-1:0] ras_q [RAS_DEPTH];

    logic [PW-1:0]   top_idx;
    logic [XLEN-1:0] ras_top;
    logic [XLEN-1:0] cand;
    logic            cand_chk;
    logic            ras_we;
    logic [PW-1:0]   ras_widx;

    assign pc        = pc_q;
    assign bad_addr  = bad_q;
    assign misalign  = mis_q;
    assign pc_plus4  = pc_q + XLEN'(4);
    assign ras_empty = (cnt_q == '0);
    assign ras_full  = (cnt_q == CW'(RAS_DEPTH));
    // ptr_q is the next write slot; the top entry sits one below it (mod depth)
    assign top_idx   = ptr_q - PW'(1);
    assign ras_top   = ras_q[top_idx];

    always_comb begin
        cand     = pc_plus4;
        cand_chk = 1'b0;
        if (trap) begin
            cand = trap_vector;
        end else if (br_taken) begin
            cand     = br_target;
            cand_chk = 1'b1;
        end else if (ras_pop && !ras_empty) begin
            cand     = ras_top;
            cand_chk = 1'b1;
        end
    end

    always_comb begin
        pc_d     = pc_q;
        bad_d    = bad_q;
        mis_d    = 1'b0;
        cnt_d    = cnt_q;
        ptr_d    = ptr_q;
        ras_we   = 1'b0;
        ras_widx = ptr_q;
        if (en) begin
            mis_d = cand_chk && (cand[1:0] != 2'b00);
            pc_d  = mis_d ? trap_vector : cand;
            if (mis_d) begin
                bad_d = cand;
            end
            if (trap) begin
                cnt_d = '0;
            end else if (ras_push && ras_pop && !ras_empty) begin
                // Return and call in one cycle: redirect used the old top above
                ras_we   = 1'b1;
                ras_widx = top_idx;
            end else if (ras_push) begin
                ras_we = 1'b1;
                ptr_d  = ptr_q + PW'(1);
                cnt_d  = ras_full ? cnt_q : cnt_q + CW'(1);
            end else if (ras_pop && !ras_empty) begin
                ptr_d = ptr_q - PW'(1);
                cnt_d = cnt_q - CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q  <= RESET_VECTOR;
            bad_q <= '0;
            mis_q <= 1'b0;
            cnt_q <= '0;
            ptr_q <= '0;
        end else begin
            pc_q  <= pc_d;
            bad_q <= bad_d;
            mis_q <= mis_d;
            cnt_q <= cnt_d;
            ptr_q <= ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (ras_we) begin
            ras_q[ras_widx] <= pc_plus4;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_next_pc_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_next_pc_unit
// Brief    : Scoreboard bench for next_pc_unit against a queue-based model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_next_pc_unit;

    localparam int          DEPTH = 4;
    localparam logic [31:0] RV    = 32'h0;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0, br_taken = 1'b0, trap = 1'b0, ras_push = 1'b0, ras_pop = 1'b0;
    logic [31:0] br_target = '0, trap_vector = '0;
    logic [31:0] pc, pc_plus4, bad_addr;
    logic        misalign, ras_empty, ras_full;

    next_pc_unit #(.XLEN(32), .RESET_VECTOR(RV), .RAS_DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .br_taken(br_taken), .br_target(br_target),
        .trap(trap), .trap_vector(trap_vector), .ras_push(ras_push), .ras_pop(ras_pop),
        .pc(pc), .pc_plus4(pc_plus4), .misalign(misalign), .bad_addr(bad_addr),
        .ras_empty(ras_empty), .ras_full(ras_full)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] bad;
        logic        mis;
        logic        emp;
        logic        full;
    } exp_t;

    exp_t        sb[$];
    int          n_checks = 0;
    int          n_fail = 0;

    logic [31:0] m_pc;
    logic [31:0] m_bad;
    logic        m_mis;
    logic [31:0] m_ras[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pc  = RV;
        m_bad = '0;
        m_mis = 1'b0;
        m_ras.delete();
    endtask

    // Drive one cycle at the falling edge and queue the state expected after the next rising edge
    task automatic step(input logic e, input logic bt, input logic [31:0] tg,
                        input logic tr, input logic [31:0] tv, input logic pu, input logic po);
        logic [31:0] cand;
        logic [31:0] ret;
        logic        chkd;
        exp_t        x;
        @(negedge clk);
        en = e; br_taken = bt; br_target = tg; trap = tr; trap_vector = tv;
        ras_push = pu; ras_pop = po;
        ret  = m_pc + 32'd4;
        cand = ret;
        chkd = 1'b0;
        if (tr) cand = tv;
        else if (bt) begin cand = tg; chkd = 1'b1; end
        else if (po && m_ras.size() > 0) begin cand = m_ras[m_ras.size()-1]; chkd = 1'b1; end
        if (e) begin
            if (chkd && cand[1:0] != 2'b00) begin
                m_bad = cand;
                m_mis = 1'b1;
                cand  = tv;
            end else begin
                m_mis = 1'b0;
            end
            if (tr) m_ras.delete();
            else if (pu && po && m_ras.size() > 0) m_ras[m_ras.size()-1] = ret;
            else if (pu) begin
                m_ras.push_back(ret);
                if (m_ras.size() > DEPTH) void'(m_ras.pop_front());
            end else if (po && m_ras.size() > 0) void'(m_ras.pop_back());
            m_pc = cand;
        end else begin
            m_mis = 1'b0;
        end
        x.pc = m_pc; x.bad = m_bad; x.mis = m_mis;
        x.emp = (m_ras.size() == 0); x.full = (m_ras.size() == DEPTH);
        sb.push_back(x);
    endtask

    task automatic idle();
        step(1'b1, 1'b0, 32'h0, 1'b0, 32'h80, 1'b0, 1'b0);
    endtask

    task automatic jump(input logic [31:0] t);
        step(1'b1, 1'b1, t, 1'b0, 32'h80, 1'b0, 1'b0);
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, ".pc"}, pc, RV);
        chk({tag, ".misalign"}, {31'd0, misalign}, 32'd0);
        chk({tag, ".ras_empty"}, {31'd0, ras_empty}, 32'd1);
    endtask

    // Monitor: one expected entry is consumed after every rising edge that follows a drive
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("pc", pc, e.pc);
                chk("pc_plus4", pc_plus4, e.pc + 32'd4);
                chk("misalign", {31'd0, misalign}, {31'd0, e.mis});
                chk("bad_addr", bad_addr, e.bad);
                chk("ras_empty", {31'd0, ras_empty}, {31'd0, e.emp});
                chk("ras_full", {31'd0, ras_full}, {31'd0, e.full});
            end
        end
    end

    initial begin
        int wait_cyc;
        logic [31:0] tg;
        model_reset();
        #12;
        check_reset_state("reset");
        chk("reset.bad_addr", bad_addr, 32'd0);
        chk("reset.ras_full", {31'd0, ras_full}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        repeat (3) idle();

        jump(32'h100);
        step(1'b1, 1'b1, 32'h200, 1'b1, 32'h80, 1'b1, 1'b0);
        jump(32'h100);
        step(1'b1, 1'b1, 32'h200, 1'b0, 32'h80, 1'b0, 1'b0);

        jump(32'h10);
        step(1'b1, 1'b0, 32'h0, 1'b0, 32'h80, 1'b1, 1'b0);
        jump(32'h40);
        step(1'b1, 1'b0, 32'h0, 1'b0, 32'h80, 1'b1, 1'b0);
        repeat (3) step(1'b1, 1'b0, 32'h0, 1'b0, 32'h80, 1'b0, 1'b1);

        repeat (5) step(1'b1, 1'b0, 32'h0, 1'b0, 32'h80, 1'b1, 1'b0);
        repeat (5) step(1'b1, 1'b0, 32'h0, 1'b0, 32'h80, 1'b0, 1'b1);

        step(1'b1, 1'b1, 32'h202, 1'b0, 32'h80, 1'b0, 1'b0);
        idle();

        // Odd trap vector is taken verbatim; a later return to pc+4 from it is misaligned
        step(1'b1, 1'b0, 32'h0, 1'b1, 32'h81, 1'b0, 1'b0);
        step(1'b1, 1'b0, 32'h0, 1'b0, 32'h300, 1'b1, 1'b0);
        step(1'b1, 1'b0, 32'h0, 1'b0, 32'h300, 1'b1, 1'b1);
        step(1'b1, 1'b0, 32'h0, 1'b0, 32'h300, 1'b0, 1'b1);
        idle();

        jump(32'hFFFF_FFFC);
        idle();

        step(1'b1, 1'b0, 32'h0, 1'b0, 32'h80, 1'b1, 1'b0);
        repeat (3) step(1'b0, 1'b1, 32'h500, 1'b0, 32'h80, 1'b1, 1'b0);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check_reset_state("async_reset");
        model_reset();
        en = 1'b0; br_taken = 1'b0; trap = 1'b0; ras_push = 1'b0; ras_pop = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        step(1'b1, 1'b1, 32'h33, 1'b0, 32'h40, 1'b0, 1'b0);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1 check_reset_state("reset_mid_pulse");
        model_reset();
        en = 1'b0; br_taken = 1'b0; trap = 1'b0; ras_push = 1'b0; ras_pop = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 400; i++) begin
            tg = $urandom & 32'hFFFF_FFFC;
            if ($urandom_range(0, 3) == 0) tg = tg | 32'($urandom_range(1, 3));
            step($urandom_range(0, 9) != 0, $urandom_range(0, 4) == 0, tg,
                 $urandom_range(0, 19) == 0,
                 ($urandom & 32'hFFF0) | (($urandom_range(0, 7) == 0) ? 32'h2 : 32'h0),
                 $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0);
        end

        wait_cyc = 0;
        while (sb.size() > 0 && wait_cyc < 10) begin
            @(posedge clk);
            wait_cyc++;
        end
        #2;
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d pending expected 0 pending", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
